// File: rtl/button_conditioner.sv
// Per-channel button conditioner: 2-flop synchroniser, debounce FSM, and
// registered press / release / long-press / auto-repeat pulses.
module button_conditioner #(
    parameter int NUM_BUTTONS       = 5,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int REPEAT_CYCLES     = 10000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_long,
    output logic [NUM_BUTTONS-1:0] btn_repeat
);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW  = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam int RPW = $clog2(REPEAT_CYCLES) + 1;

    localparam logic LONG_EN = (LONG_PRESS_CYCLES > 0);
    localparam logic REP_EN  = (LONG_PRESS_CYCLES > 0) && (REPEAT_CYCLES > 0);

    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [RPW-1:0] REP_LAST  = RPW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic sync1_reg;
        (* ASYNC_REG = "TRUE" *) logic sync2_reg;

        state_t         state_reg, state_next;
        logic [DW-1:0]  cnt_reg, cnt_next;
        logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;
        logic [RPW-1:0] rep_cnt_reg, rep_cnt_next;
        logic           press_reg, press_next;
        logic           rel_reg, rel_next;
        logic           long_reg, long_next;
        logic           rpt_reg, rpt_next;
        logic           s;
        logic           counting;

        assign s = sync2_reg;
        // Hold time accumulates on every high sample while pressed, so a short
        // release glitch delays the long/repeat timing by exactly its length.
        assign counting = s && (state_reg == HELD || state_reg == RELEASE_WAIT);

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_reg    <= 1'b0;
                sync2_reg    <= 1'b0;
                state_reg    <= IDLE;
                cnt_reg      <= '0;
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
                press_reg    <= 1'b0;
                rel_reg      <= 1'b0;
                long_reg     <= 1'b0;
                rpt_reg      <= 1'b0;
            end else begin
                sync1_reg    <= btn_in[gi];
                sync2_reg    <= sync1_reg;
                state_reg    <= state_next;
                cnt_reg      <= cnt_next;
                hold_cnt_reg <= hold_cnt_next;
                rep_cnt_reg  <= rep_cnt_next;
                press_reg    <= press_next;
                rel_reg      <= rel_next;
                long_reg     <= long_next;
                rpt_reg      <= rpt_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
                IDLE: begin
                    if (s) begin
                        state_next = PRESS_WAIT;
                        cnt_next   = DW'(1);
                    end else begin
                        cnt_next = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + DW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = DW'(1);
                    end
                end
                default: begin
                    if (s) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + DW'(1);
                    end
                end
            endcase
        end

        always_comb begin
            press_next    = 1'b0;
            rel_next      = 1'b0;
            long_next     = 1'b0;
            rpt_next      = 1'b0;
            hold_cnt_next = hold_cnt_reg;
            rep_cnt_next  = rep_cnt_reg;
            if (state_reg == PRESS_WAIT && s && cnt_reg == DEB_LAST) begin
                press_next    = 1'b1;
                hold_cnt_next = '0;
                rep_cnt_next  = '0;
            end
            if (state_reg == RELEASE_WAIT && !s && cnt_reg == DEB_LAST) begin
                rel_next = 1'b1;
            end
            // hold_cnt parks at HOLD_MAX once the long pulse has fired.
            if (counting && LONG_EN) begin
                if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                    long_next     = (hold_cnt_reg == HOLD_LAST);
                end else if (REP_EN) begin
                    if (rep_cnt_reg == REP_LAST) begin
                        rpt_next     = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + RPW'(1);
                    end
                end
            end
        end

        assign btn_level[gi]   = (state_reg == HELD) || (state_reg == RELEASE_WAIT);
        assign btn_press[gi]   = press_reg;
        assign btn_release[gi] = rel_reg;
        assign btn_long[gi]    = long_reg;
        assign btn_repeat[gi]  = rpt_reg;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timing scenarios plus randomized
// traffic, all compared every cycle against an event-level reference model.
module tb_button_conditioner;
    localparam int NB = 2;
    localparam int D  = 4;
    localparam int L  = 10;
    localparam int R  = 3;

    logic          clk;
    logic          reset;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

    button_conditioner #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_long(btn_long), .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: a sample of s is the raw input two edges earlier; a
    // press/release is a run of D equal samples; hold time is the number of
    // high samples seen since the press.
    logic [NB-1:0] m_s1, m_s2, m_pressed;
    int            m_run[NB];
    int            m_h[NB];
    logic [NB-1:0] e_press, e_rel, e_long, e_rpt;
    logic          model_ready = 1'b0;

    always @(posedge clk) begin
        logic s;
        for (int i = 0; i < NB; i++) begin
            e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0; e_rpt[i] = 1'b0;
            if (reset) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_pressed[i] = 1'b0;
                m_run[i] = 0; m_h[i] = 0;
            end else begin
                s = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_in[i];
                if (!m_pressed[i]) begin
                    m_run[i] = s ? m_run[i] + 1 : 0;
                    if (m_run[i] == D) begin
                        m_pressed[i] = 1'b1; e_press[i] = 1'b1; m_run[i] = 0; m_h[i] = 0;
                    end
                end else if (s) begin
                    m_run[i] = 0;
                    m_h[i]++;
                    if (L > 0 && m_h[i] == L) e_long[i] = 1'b1;
                    else if (L > 0 && R > 0 && m_h[i] > L && (m_h[i] - L) % R == 0) e_rpt[i] = 1'b1;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_pressed[i] = 1'b0; e_rel[i] = 1'b1; m_run[i] = 0;
                    end
                end
            end
        end
        model_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("model_cycle",
                  {6'd0, btn_level, btn_press, btn_release, btn_long, btn_repeat},
                  {6'd0, m_pressed, e_press, e_rel, e_long, e_rpt});
        end
    end

    int tmr[NB];

    initial begin
        btn_in = '0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {6'd0, btn_level, btn_press, btn_release, btn_long, btn_repeat}, 16'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_cycle_after_reset", {6'd0, btn_level, btn_press, btn_release, btn_long, btn_repeat}, 16'd0);

        // Long press with repeats: press at edge 5, long at 15, repeats at 18/21/24.
        btn_in = 2'b01;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            check($sformatf("hold_timing_k%0d", k),
                  {12'd0, btn_press[0], btn_long[0], btn_repeat[0], btn_level[0]},
                  {12'd0, k == 5, k == 15, (k == 18 || k == 21 || k == 24), k >= 5});
        end

        // Release: pulse 5 edges after the low level is first sampled.
        btn_in[0] = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("release_k%0d", k), {14'd0, btn_release[0], btn_level[0]},
                  {14'd0, k == 5, k < 5});
        end
        repeat (4) @(negedge clk);

        // Bounce: 3 high / 3 low never satisfies the debounce.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 6; k++) begin
                btn_in[0] = (k < 3);
                @(negedge clk);
                check($sformatf("bounce_b%0d_k%0d", b, k), {14'd0, btn_press[0], btn_level[0]}, 16'd0);
            end
        end
        btn_in[0] = 1'b0;
        repeat (8) @(negedge clk);

        // Two-sample glitch while held shifts long/repeat by 2, no release.
        btn_in[0] = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            check($sformatf("glitch_k%0d", k),
                  {12'd0, btn_press[0], btn_long[0], btn_repeat[0], btn_release[0]},
                  {12'd0, k == 5, k == 17, (k == 20 || k == 23 || k == 26), 1'b0});
            if (k == 6) btn_in[0] = 1'b0;
            if (k == 8) btn_in[0] = 1'b1;
        end
        btn_in[0] = 1'b0;
        repeat (12) @(negedge clk);

        // Simultaneous press on both channels.
        btn_in = 2'b11;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("dual_press_k%0d", k), {14'd0, btn_press}, (k == 5) ? 16'd3 : 16'd0);
        end

        // Reset during HELD: no release, re-debounce after reset.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset_in_hold_k%0d", k),
                  {6'd0, btn_level, btn_press, btn_release, btn_long, btn_repeat}, 16'd0);
        end
        reset = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("repress_after_reset_k%0d", k), {12'd0, btn_press, btn_release},
                  (k == 5) ? 16'hC : 16'd0);
        end
        btn_in = '0;
        repeat (10) @(negedge clk);

        // Randomized traffic: mix of bounces and long holds, occasional reset.
        for (int i = 0; i < NB; i++) tmr[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (tmr[i] == 0) begin
                    btn_in[i] = ~btn_in[i];
                    tmr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 6);
                end else begin
                    tmr[i]--;
                end
            end
            reset = ($urandom_range(0, 599) == 0);
        end
        reset  = 1'b0;
        btn_in = '0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BUTTONS, default 5: number of independent button channels, minimum 1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable synchronised samples needed to accept a press or release, minimum 2.
REQ-003 Parameter LONG_PRESS_CYCLES, default 50000000: held cycles after the press pulse before btn_long fires; 0 disables btn_long and btn_repeat.
REQ-004 Parameter REPEAT_CYCLES, default 10000000: auto-repeat period after btn_long; 0 disables btn_repeat.
REQ-005 clk  input  1  clock; all logic is on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 btn_in  input  NUM_BUTTONS  raw asynchronous button levels, bit i = channel i.
REQ-008 btn_level  output  NUM_BUTTONS  debounced level: 1 in HELD and RELEASE_WAIT.
REQ-009 btn_press  output  NUM_BUTTONS  1-cycle pulse on accepted press.
REQ-010 btn_release  output  NUM_BUTTONS  1-cycle pulse on accepted release.
REQ-011 btn_long  output  NUM_BUTTONS  1-cycle pulse on long-press threshold.
REQ-012 btn_repeat  output  NUM_BUTTONS  1-cycle pulse on each auto-repeat tick.

Function
REQ-013 Each channel SHALL pass btn_in[i] through a 2-flop synchroniser marked ASYNC_REG; the FSM samples s = second flop output.
REQ-014 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-015 Per-channel FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-016 IDLE with s=1 SHALL go to PRESS_WAIT with cnt=1; IDLE with s=0 SHALL stay in IDLE.
REQ-017 PRESS_WAIT with s=0 SHALL return to IDLE with cnt=0 and no pulse.
REQ-018 PRESS_WAIT with s=1 and cnt=DEBOUNCE_CYCLES-1 SHALL enter HELD, assert btn_press for one cycle and clear hold_cnt; otherwise it SHALL increment cnt.
REQ-019 Press latency SHALL be DEBOUNCE_CYCLES+1 edges after the first edge at which btn_in is sampled high, provided btn_in stays high throughout.
REQ-020 HELD with s=0 SHALL go to RELEASE_WAIT with cnt=1, and hold_cnt and rep_cnt SHALL freeze.
REQ-021 RELEASE_WAIT with s=1 SHALL return to HELD, with the frozen counters resuming and no pulse.
REQ-022 RELEASE_WAIT with s=0 and cnt=DEBOUNCE_CYCLES-1 SHALL go to IDLE and assert btn_release for one cycle; otherwise it SHALL increment cnt.
REQ-023 In HELD with s=1, hold_cnt SHALL increment each cycle; btn_long SHALL pulse when hold_cnt=LONG_PRESS_CYCLES-1, i.e. exactly LONG_PRESS_CYCLES cycles after btn_press, once per press.
REQ-024 After btn_long, rep_cnt SHALL count HELD s=1 cycles; btn_repeat SHALL pulse every REPEAT_CYCLES cycles, the first pulse coming REPEAT_CYCLES cycles after btn_long, and rep_cnt SHALL wrap to 0 on each pulse.
REQ-025 hold_cnt SHALL saturate after btn_long and SHALL never wrap.
REQ-026 Counter widths SHALL be $clog2 of the respective parameter +1; pulses SHALL be registered outputs.
REQ-027 btn_press, btn_long and btn_repeat SHALL never assert in the same cycle on one channel; btn_press and btn_release SHALL strictly alternate per channel, starting with btn_press.

Reset
REQ-028 While reset=1, all FSMs SHALL be IDLE, all counters and synchroniser flops 0, and all outputs 0.
REQ-029 Reset asserted mid-press or mid-hold SHALL abort the sequence with no btn_release pulse; after reset deasserts, a still-held button SHALL be re-debounced from IDLE.
REQ-030 Outputs SHALL be 0 in the first cycle after reset deasserts.

Verification (NUM_BUTTONS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3)
REQ-031 btn_in[0] rises at edge 0 and stays high -> btn_press[0] pulses after edge 5; btn_level[0]=1 from then; btn_long[0] pulses after edge 15; btn_repeat[0] pulses after edges 18, 21, 24.
REQ-032 btn_in[0] high for 3 cycles, then low, repeated (bounce) -> no pulses, btn_level[0] stays 0.
REQ-033 While held, btn_in[0] drops for 2 cycles -> no btn_release; hold timing shifts by exactly 2 cycles (frozen counters).
REQ-034 Release held for 4+ cycles -> btn_release[0] pulses once, 5 edges after the falling edge is first sampled; btn_level[0]=0.
REQ-035 Both channels pressed on the same edge -> btn_press[1:0]=2'b11 in the same cycle.
REQ-036 reset pulsed during HELD -> all outputs 0, no btn_release; button still high -> btn_press again DEBOUNCE_CYCLES+1 edges after reset deasserts.
